// File: rtl/ec_pkg.sv
// Shared encodings and width defaults for the accumulator datapath and its control unit.
package ec_pkg;

  localparam int EC_DATA_W = 8;
  localparam int EC_ADDR_W = 5;

  typedef enum logic [1:0] {
    ASEL_ALU  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_IN    = 3'b100,
    OP_JZ    = 3'b101,
    OP_JPOS  = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

endpackage

// File: rtl/ec_ram.sv
// Single-port program/data RAM with loader write mux; registered read, 1-cycle latency.
// Read-during-write to the same address returns old data; no backpressure.
module ec_ram
  import ec_pkg::*;
#(
  parameter int DATA_W = EC_DATA_W,
  parameter int ADDR_W = EC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_d;

  // Loader wins over the datapath store so boot writes are never lost.
  always_comb begin
    we    = ld_we | wr_en;
    waddr = ld_we ? ld_addr : addr;
    wdata = ld_we ? ld_data : wr_data;
    rd_d  = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

endmodule

// File: rtl/ec_datapath.sv
// Accumulator datapath: PC, IR, A, ALU and RAM; register updates take effect on the next edge.
// Halt freezes all state except the loader; optional sticky ovf output under EC_OVERFLOW_FLAG_EN.
module ec_datapath
  import ec_pkg::*;
#(
  parameter int DATA_W = EC_DATA_W,
  parameter int ADDR_W = EC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MenWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              Sub,
  input  logic              Halt,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [2:0]        IR,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] A_out,
  output logic [ADDR_W-1:0] PC_out,
  output logic              halted
`ifdef EC_OVERFLOW_FLAG_EN
  , output logic            ovf
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] alu_res;
  logic              mem_wr;

  ec_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .wr_en   (mem_wr),
    .addr    (addr),
    .wr_data (a_q),
    .rd_q    (rd_q)
  );

  always_comb begin
    addr     = Meminst ? ir_q[ADDR_W-1:0] : pc_q;
    mem_wr   = MenWr & ~Halt;
    alu_res  = Sub ? (a_q - rd_q) : (a_q + rd_q);
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    halted_d = Halt;
    if (!Halt) begin
      if (PCload) begin
        pc_d = JMPmux ? ir_q[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      end
      if (IRload) begin
        ir_d = rd_q;
      end
      if (Aload) begin
        case (asel_e'(Asel))
          ASEL_ALU:  a_d = alu_res;
          ASEL_IN:   a_d = in_data;
          ASEL_MEM:  a_d = rd_q;
          ASEL_ZERO: a_d = '0;
          default:   a_d = a_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      halted_q <= halted_d;
    end
  end

  // Flags look at the A register, not the ALU, so jumps see the previous result.
  assign IR     = ir_q[DATA_W-1 -: 3];
  assign Aeq0   = (a_q == '0);
  assign Apos   = ~a_q[DATA_W-1];
  assign A_out  = a_q;
  assign PC_out = pc_q;
  assign halted = halted_q;

`ifdef EC_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  logic ovf_hit;

  always_comb begin
    if (Sub) begin
      ovf_hit = (a_q[DATA_W-1] != rd_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    end else begin
      ovf_hit = (a_q[DATA_W-1] == rd_q[DATA_W-1]) && (alu_res[DATA_W-1] != a_q[DATA_W-1]);
    end
    ovf_d = ovf_q;
    if (Aload && !Halt && (asel_e'(Asel) == ASEL_ALU) && ovf_hit) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ec_datapath.sv
// Directed bench for ec_datapath: hand-computed expectations checked with immediate assertions.
module tb_ec_datapath;
  import ec_pkg::*;

  localparam int DW = 8;
  localparam int AW = 5;

  logic          clk, reset;
  logic          IRload, JMPmux, PCload, Meminst, MenWr, Aload, Sub, Halt, ld_we;
  logic [1:0]    Asel;
  logic [DW-1:0] in_data, ld_data;
  logic [AW-1:0] ld_addr;
  logic [2:0]    IR;
  logic          Aeq0, Apos, halted;
  logic [DW-1:0] A_out;
  logic [AW-1:0] PC_out;
`ifdef EC_OVERFLOW_FLAG_EN
  logic          ovf;
`endif

  int checks = 0;
  int errors = 0;

  ec_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .IRload  (IRload),
    .JMPmux  (JMPmux),
    .PCload  (PCload),
    .Meminst (Meminst),
    .MenWr   (MenWr),
    .Asel    (Asel),
    .Aload   (Aload),
    .Sub     (Sub),
    .Halt    (Halt),
    .in_data (in_data),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .IR      (IR),
    .Aeq0    (Aeq0),
    .Apos    (Apos),
    .A_out   (A_out),
    .PC_out  (PC_out),
    .halted  (halted)
`ifdef EC_OVERFLOW_FLAG_EN
    , .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MenWr = 0;
    Asel = 2'b00; Aload = 0; Sub = 0; Halt = 0; ld_we = 0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle();
    ld_we = 1; ld_addr = a; ld_data = d;
    tick();
    idle();
  endtask

  task automatic fetch();
    idle();
    tick();
    IRload = 1; PCload = 1;
    tick();
    idle();
  endtask

  task automatic jump();
    idle();
    JMPmux = 1; PCload = 1;
    tick();
    idle();
  endtask

  task automatic decode();
    idle();
    Meminst = 1;
    tick();
    idle();
  endtask

  task automatic alu(input logic sub);
    idle();
    Asel = 2'b00; Sub = sub; Aload = 1;
    tick();
    idle();
  endtask

  task automatic ld_a_mem();
    idle();
    Asel = 2'b10; Aload = 1;
    tick();
    idle();
  endtask

  task automatic ld_a_in(input logic [DW-1:0] v);
    idle();
    in_data = v; Asel = 2'b01; Aload = 1;
    tick();
    idle();
  endtask

  initial begin
    reset = 1; idle();
    in_data = '0; ld_addr = '0; ld_data = '0;
    #2 reset = 0;
    #20;
    check("rst_a", A_out, 0);
    check("rst_pc", PC_out, 0);
    check("rst_ir", IR, 0);
    check("rst_aeq0", Aeq0, 1);
    check("rst_apos", Apos, 1);
    check("rst_halted", halted, 0);
    reset = 1;
    tick();

    // Fetch, jump and PC wrap
    load(0, 8'hA7); load(7, 8'h3F); load(31, 8'h00);
    fetch();
    check("fetch_op", IR, 3'b101);
    check("fetch_pc", PC_out, 1);
    jump();
    check("jump_pc", PC_out, 7);
    fetch();
    check("fetch2_pc", PC_out, 8);
    jump();
    check("jump31_pc", PC_out, 31);
    fetch();
    check("pc_wrap", PC_out, 0);

    // Load / add / sub program
    load(0, 8'h04); load(1, 8'h45); load(2, 8'h64);
    load(3, 8'h23); load(4, 8'h05); load(5, 8'hFB);
    fetch(); decode(); ld_a_mem();
    check("load_a", A_out, 8'h05);
    check("load_op", IR, 3'b000);
    fetch(); decode(); alu(0);
    check("add_a", A_out, 8'h00);
    check("add_aeq0", Aeq0, 1);
    check("add_op", IR, 3'b010);
    fetch(); decode(); alu(1);
    check("sub_a", A_out, 8'hFB);
    check("sub_apos", Apos, 0);
    check("sub_aeq0", Aeq0, 0);

    // Store with read-during-write, then loader priority
    fetch();
    check("store_op", IR, 3'b001);
    ld_a_in(8'h5A);
    check("in_a", A_out, 8'h5A);
    idle(); Meminst = 1; MenWr = 1;
    tick();
    MenWr = 0; Asel = 2'b10; Aload = 1;
    tick();
    check("rdw_old", A_out, 8'h23);
    tick();
    check("store_rd", A_out, 8'h5A);
    idle(); Meminst = 1; MenWr = 1; ld_we = 1; ld_addr = 3; ld_data = 8'h11;
    tick();
    idle(); decode(); ld_a_mem();
    check("ld_prio", A_out, 8'h11);

    // Halt freezes state, loader still writes
    ld_a_in(8'h66);
    idle();
    Halt = 1; PCload = 1; Aload = 1; Asel = 2'b11; MenWr = 1; Meminst = 1; IRload = 1;
    tick();
    check("halt_pc", PC_out, 4);
    check("halt_a", A_out, 8'h66);
    check("halt_ir", IR, 3'b001);
    check("halt_flag", halted, 1);
    idle(); Meminst = 1;
    tick();
    check("unhalt_flag", halted, 0);
    ld_a_mem();
    check("halt_ram", A_out, 8'h11);
    idle(); Halt = 1; MenWr = 1; Meminst = 1; ld_we = 1; ld_addr = 3; ld_data = 8'h77;
    tick();
    idle(); decode(); ld_a_mem();
    check("halt_loader", A_out, 8'h77);

    // Asynchronous reset mid-cycle
    load(4, 8'h29);
    fetch(); jump();
    ld_a_in(8'h37);
    check("pre_rst_pc", PC_out, 9);
    check("pre_rst_a", A_out, 8'h37);
    #3 reset = 0;
    #1;
    check("arst_a", A_out, 0);
    check("arst_pc", PC_out, 0);
    check("arst_ir", IR, 0);
    check("arst_aeq0", Aeq0, 1);
    check("arst_apos", Apos, 1);
    #2 reset = 1;
    tick();

`ifdef EC_OVERFLOW_FLAG_EN
    check("ovf_rst", ovf, 0);
    load(0, 8'h01);
    ld_a_in(8'h7F);
    alu(0);
    check("ovf_add_a", A_out, 8'h80);
    check("ovf_add", ovf, 1);
    idle(); Asel = 2'b11; Aload = 1;
    tick();
    idle();
    check("ovf_zero_a", A_out, 0);
    check("ovf_sticky", ovf, 1);
    reset = 0;
    #2;
    check("ovf_clr", ovf, 0);
    reset = 1;
    tick();
    ld_a_in(8'h80);
    alu(1);
    check("ovf_sub_a", A_out, 8'h7F);
    check("ovf_sub", ovf, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
